// File: rtl/synt_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// synt_pkg : state encoding and timing defaults for the synthesizer sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package synt_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PWRUP  = 3'd1,
      CAL    = 3'd2,
      LOCKED = 3'd3,
      OFF    = 3'd4,
      FAIL   = 3'd5
   } synt_state_e;

   localparam int unsigned CYC_PER_US      = 5;
   localparam int unsigned TCAL_TRDY_CYC   = 60;
   localparam int unsigned T_PU_CYC_DEF    = 2 * CYC_PER_US;
   localparam int unsigned TIMEOUT_CYC_DEF = 15 * CYC_PER_US;
   localparam int unsigned T_OFF_CYC_DEF   = CYC_PER_US;
   localparam int unsigned MAX_RETRY_DEF   = 2;
   localparam int unsigned CNT_W_DEF       = 16;

endpackage
`default_nettype wire

// File: rtl/synt_dly_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// synt_dly_cnt : loadable down-counter that saturates at zero, with zero flag
// Rev 1.0
// ---------------------------------------------------------------------------
module synt_dly_cnt
   import synt_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/synt_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// synt_ctrl : synthesizer power-up / calibration sequencer (PU, CAL, RDY)
// Optional retry path enabled by macro SYNT_CTRL_RETRY_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module synt_ctrl
   import synt_pkg::*;
#(
   parameter int unsigned T_PU_CYC    = T_PU_CYC_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int unsigned T_OFF_CYC   = T_OFF_CYC_DEF,
`ifdef SYNT_CTRL_RETRY_EN
   parameter int unsigned MAX_RETRY   = MAX_RETRY_DEF,
`endif
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic stop_i,
   input  logic rdy_synt_i,
   output logic pu_synt_o,
   output logic cal_synt_o,
   output logic synt_lock_o,
   output logic synt_err_o,
   output logic busy_o
);

   localparam logic [CNT_W-1:0] c_pu_load  = CNT_W'(T_PU_CYC - 1);
   localparam logic [CNT_W-1:0] c_to_load  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] c_off_load = CNT_W'(T_OFF_CYC - 1);

   synt_state_e      state_q;
   logic             pu_q, cal_q, lock_q, err_q, busy_q;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_zero;
   logic             retry_ok;
   logic             go_off;

`ifdef SYNT_CTRL_RETRY_EN
   localparam int unsigned c_retry_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [c_retry_w-1:0] retry_q;
   assign retry_ok = (retry_q < c_retry_w'(MAX_RETRY));
`else
   assign retry_ok = 1'b0;
`endif

   // Timeout or lock loss that still has retries left powers down through OFF.
   assign go_off = !stop_i && !rdy_synt_i && retry_ok &&
                   (((state_q == CAL) && cnt_zero) || (state_q == LOCKED));

   always_comb begin
      cnt_load     = 1'b0;
      cnt_load_val = c_off_load;
      if (stop_i || go_off) begin
         cnt_load = 1'b1;
      end else begin
         case (state_q)
            IDLE:    if (start_i && cnt_zero) begin cnt_load = 1'b1; cnt_load_val = c_pu_load; end
            PWRUP:   if (cnt_zero)            begin cnt_load = 1'b1; cnt_load_val = c_to_load; end
            OFF:     if (cnt_zero)            begin cnt_load = 1'b1; cnt_load_val = c_pu_load; end
            default: ;
         endcase
      end
   end

   synt_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i || stop_i) begin
         state_q <= IDLE;
         pu_q    <= 1'b0;
         cal_q   <= 1'b0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i && cnt_zero) begin
                  state_q <= PWRUP;
                  pu_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            PWRUP: begin
               if (cnt_zero) begin
                  state_q <= CAL;
                  cal_q   <= 1'b1;
               end
            end
            CAL: begin
               // RDY takes precedence over a timeout expiring on the same edge.
               if (rdy_synt_i) begin
                  state_q <= LOCKED;
                  cal_q   <= 1'b0;
                  lock_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else if (cnt_zero) begin
                  pu_q  <= 1'b0;
                  cal_q <= 1'b0;
                  if (go_off) begin
                     state_q <= OFF;
                  end else begin
                     state_q <= FAIL;
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            LOCKED: begin
               pu_q <= 1'b1;
               if (!rdy_synt_i) begin
                  lock_q <= 1'b0;
                  pu_q   <= 1'b0;
                  if (go_off) begin
                     state_q <= OFF;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= FAIL;
                     err_q   <= 1'b1;
                  end
               end
            end
            OFF: begin
               if (cnt_zero) begin
                  state_q <= PWRUP;
                  pu_q    <= 1'b1;
               end
            end
            FAIL: ;
            default: begin
               state_q <= IDLE;
               pu_q    <= 1'b0;
               cal_q   <= 1'b0;
               lock_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
`ifdef SYNT_CTRL_RETRY_EN
      if (rst_i || stop_i || (state_q == IDLE) || ((state_q == CAL) && rdy_synt_i)) begin
         retry_q <= '0;
      end else if (go_off) begin
         retry_q <= retry_q + 1'b1;
      end
`endif
   end

   assign pu_synt_o   = pu_q;
   assign cal_synt_o  = cal_q;
   assign synt_lock_o = lock_q;
   assign synt_err_o  = err_q;
   assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_synt_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_synt_ctrl : self-checking bench for the synthesizer sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_synt_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic rdy = 1'b0;
   logic pu, cal, lock, err, busy;

   int checks = 0;
   int failures = 0;

   synt_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .stop_i      (stop),
      .rdy_synt_i  (rdy),
      .pu_synt_o   (pu),
      .cal_synt_o  (cal),
      .synt_lock_o (lock),
      .synt_err_o  (err),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   // Expected output bundle order: {pu, cal, lock, err, busy}
   typedef struct {
      logic       start;
      logic       stop;
      logic       rdy;
      logic [4:0] exp;
   } vec_t;

   typedef struct {
      logic [4:0] exp;
      int         idx;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];

   function automatic logic [4:0] outs();
      return {pu, cal, lock, err, busy};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; rdy = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic wait_cal(input string name);
      int n = 0;
      while (!cal && n < 40) begin
         tick();
         n++;
      end
      check(name, cal, 1);
   endtask

   // Returns number of consecutive samples with CAL high, starting at a high sample.
   task automatic cal_window(output int n);
      n = 0;
      while (cal && n < 200) begin
         n++;
         tick();
      end
   endtask

   function automatic void addv(logic s, logic p, logic r, logic [4:0] e, int cnt);
      for (int i = 0; i < cnt; i++) vecs.push_back('{s, p, r, e});
   endfunction

   initial begin
      int n, gap, calcnt, pu_at, cal_at, lock_at;
      logic prev_cal, cal_at_lock;

      tick(); tick();
      check("reset_outs", outs(), 5'b00000);
      rst = 1'b0;

      addv(0, 0, 0, 5'b00000, 2);   // idle
      addv(1, 1, 0, 5'b00000, 1);   // STOP beats START
      addv(1, 0, 0, 5'b00000, 4);   // off time not yet expired
      addv(1, 0, 0, 5'b10001, 1);   // START accepted
      addv(0, 0, 0, 5'b10001, 9);   // PWRUP settling
      addv(0, 0, 0, 5'b11001, 6);   // CAL
      addv(0, 0, 1, 5'b10100, 4);   // LOCKED
      addv(1, 0, 1, 5'b10100, 1);   // START ignored while locked
      addv(0, 1, 1, 5'b00000, 1);   // STOP clears everything

      foreach (vecs[i]) begin
         sb_t e;
         start = vecs[i].start; stop = vecs[i].stop; rdy = vecs[i].rdy;
         sb_q.push_back('{vecs[i].exp, i});
         tick();
         e = sb_q.pop_front();
         check($sformatf("vec%0d", e.idx), outs(), e.exp);
      end
      check("sb_drain", sb_q.size(), 0);

      // Nominal bring-up against a synthesizer needing 60 CAL cycles.
      do_reset();
      start = 1'b1; rdy = 1'b0;
      calcnt = 0; prev_cal = 1'b0; pu_at = -1; cal_at = -1; lock_at = -1; cal_at_lock = 1'b1;
      for (int k = 1; k <= 120 && lock_at < 0; k++) begin
         tick();
         start = 1'b0;
         if (pu && pu_at < 0) pu_at = k;
         if (cal && cal_at < 0) cal_at = k;
         if (lock) begin lock_at = k; cal_at_lock = cal; end
         if (prev_cal) calcnt++;
         prev_cal = cal;
         rdy = (calcnt >= 60);
      end
      check("nom_pu_cycle", pu_at, 1);
      check("nom_cal_cycle", cal_at, 11);
      check($sformatf("nom_lock_72_74 (lock at %0d)", lock_at), (lock_at >= 72 && lock_at <= 74), 1);
      check("nom_cal_drop_at_lock", cal_at_lock, 0);
      check("nom_err", err, 0);
      rdy = 1'b0; stop = 1'b1; tick(); stop = 1'b0;

`ifdef SYNT_CTRL_RETRY_EN
      // Three timed-out CAL windows separated by power-off gaps, then FAIL.
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      for (int w = 0; w < 3; w++) begin
         if (w > 0) begin
            gap = 0;
            while (!pu && gap < 50) begin tick(); gap++; end
            check($sformatf("retry_gap%0d_ge5 (gap %0d)", w, gap), (gap >= 5), 1);
         end
         wait_cal($sformatf("retry_cal_rise%0d", w));
         cal_window(n);
         check($sformatf("retry_window%0d_len", w), n, 75);
         check($sformatf("retry_after_window%0d", w), outs(), (w < 2) ? 5'b00001 : 5'b00010);
      end
      stop = 1'b1; tick(); stop = 1'b0;
      check("retry_stop_clears", outs(), 5'b00000);

      // RDY in the second window locks without error.
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      wait_cal("retry2_cal_rise0");
      cal_window(n);
      wait_cal("retry2_cal_rise1");
      rdy = 1'b1; tick();
      check("retry2_locked", outs(), 5'b10100);
      // Lock loss takes the retry path rather than failing.
      rdy = 1'b0; tick();
      check("retry_lockloss_off", outs(), 5'b00001);
      stop = 1'b1; tick(); stop = 1'b0;
`else
      // No RDY: single 75-cycle CAL window, then FAIL.
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      wait_cal("to_cal_rise");
      cal_window(n);
      check("to_window_len", n, 75);
      check("to_fail_outs", outs(), 5'b00010);
      start = 1'b1; tick(); tick(); tick();
      check("to_start_ignored", outs(), 5'b00010);
      start = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
      check("to_stop_clears", outs(), 5'b00000);

      // Lock loss for one cycle.
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      wait_cal("ll_cal_rise");
      rdy = 1'b1; tick(); tick();
      check("ll_locked", lock, 1);
      rdy = 1'b0; tick(); rdy = 1'b1;
      check("ll_lock_drop", lock, 0);
      check("ll_err_set", err, 1);
      tick();
      check("ll_err_sticky", {lock, err, busy}, 3'b010);
      stop = 1'b1; tick(); stop = 1'b0; rdy = 1'b0;
`endif

      // STOP mid-CAL at cycle 30, then off time before next START.
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 2; k <= 30; k++) tick();
      check("stopcal_in_cal", cal, 1);
      stop = 1'b1; tick(); stop = 1'b0;
      check("stopcal_outs", outs(), 5'b00000);
      start = 1'b1; gap = 0;
      while (!pu && gap < 20) begin tick(); gap++; end
      check("stopcal_restart_delay", gap, 5);
      start = 1'b0; stop = 1'b1; tick(); stop = 1'b0;

      // RST mid-PWRUP.
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      check("rst_pwrup_pu", {pu, busy}, 2'b11);
      rst = 1'b1; tick();
      check("rst_pwrup_outs", outs(), 5'b00000);
      rst = 1'b0;

      // RDY on the very edge the timeout expires.
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      wait_cal("coin_cal_rise");
      for (int k = 1; k <= 74; k++) tick();
      check("coin_still_cal", cal, 1);
      rdy = 1'b1; tick();
      check("coin_locked", outs(), 5'b10100);
      rdy = 1'b0; stop = 1'b1; tick(); stop = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/synt_ctrl.md
# synt_ctrl

Synthesizer power-up and calibration sequencer: the initiator side of the synthesizer handshake (PU_SYNT, CAL_SYNT out; RDY_SYNT in). On a radio-on request it powers the synthesizer, waits a settling time, then holds calibration until the synthesizer reports ready, supervising with a timeout and lock-loss detection. It sits in the radio control path between the top-level mode FSM and the synthesizer.

## Interface
- T_PU_CYC, 10 — settling cycles between PU_SYNT rise and CAL_SYNT rise (2 µs at 5 cycles/µs).
- TIMEOUT_CYC, 75 — maximum CAL cycles waiting for RDY_SYNT (15 µs; must exceed the 60-cycle Tcal+Trdy).
- T_OFF_CYC, 5 — PU_SYNT low time before a retry.
- MAX_RETRY, 2 — retries after a timeout (used only with the retry feature).
- CNT_W, 16 — width of the shared delay counter; must hold the largest of T_PU_CYC, TIMEOUT_CYC and T_OFF_CYC.
- CLK  in  1  system clock, 5 cycles per µs.
- RST  in  1  synchronous, active-high reset.
- START  in  1  level-sampled request to bring the synthesizer up.
- STOP  in  1  request to power down; has priority over START.
- RDY_SYNT  in  1  synthesizer ready.
- PU_SYNT  out  1  synthesizer power-up.
- CAL_SYNT  out  1  calibration enable.
- SYNT_LOCK  out  1  synthesizer calibrated and ready.
- SYNT_ERR  out  1  sticky failure flag (timeout or lock loss); cleared by STOP or RST.
- BUSY  out  1  sequence in progress (PWRUP, CAL or OFF).

## Operation
- All outputs are registered. Reset values: PU_SYNT=0, CAL_SYNT=0, SYNT_LOCK=0, SYNT_ERR=0, BUSY=0. State after reset is IDLE.
- IDLE: all outputs 0 except a held SYNT_ERR. START=1 and STOP=0 → PWRUP. Load counter=T_PU_CYC−1, PU_SYNT=1, BUSY=1.
- PWRUP: decrement the counter. At 0 → CAL. Set CAL_SYNT=1 and load counter=TIMEOUT_CYC−1.
- CAL: if RDY_SYNT=1 → LOCKED. Set CAL_SYNT=0, SYNT_LOCK=1, BUSY=0. Otherwise, when the counter reaches 0 → timeout handling.
- Timeout handling: → FAIL. PU_SYNT=0, CAL_SYNT=0, SYNT_ERR=1, BUSY=0.
- LOCKED: PU_SYNT=1. If RDY_SYNT=0 (lock loss) → FAIL. Set SYNT_LOCK=0 and SYNT_ERR=1.
- FAIL: stays in FAIL until STOP; STOP → IDLE. START is ignored in FAIL.
- STOP=1 in any state → IDLE on the next edge. PU_SYNT, CAL_SYNT, SYNT_LOCK, SYNT_ERR and BUSY all go to 0. This covers a STOP arriving mid-CAL or mid-PWRUP.
- Simultaneous events:
  - RDY_SYNT=1 on the same edge the timeout counter reaches 0: RDY wins and the block goes to LOCKED.
  - START and STOP both high: STOP wins.
- RST has priority over everything.

## Timing
- START sampled at edge k → PU_SYNT=1 after edge k.
- CAL_SYNT=1 after edge k+T_PU_CYC.
- RDY_SYNT high at edge m while in CAL → SYNT_LOCK=1 and CAL_SYNT=0 after edge m (1-cycle latency).
- Timeout: FAIL is entered TIMEOUT_CYC cycles after CAL_SYNT rises when no RDY_SYNT arrives.
- PU_SYNT is low for at least T_OFF_CYC cycles between any two power-up attempts.

## Configuration
- SYNT_CTRL_RETRY_EN defined:
  - A timeout with retry_cnt < MAX_RETRY → OFF state instead of FAIL. Set PU_SYNT=0, CAL_SYNT=0, retry_cnt+1, counter=T_OFF_CYC−1, BUSY=1.
  - When the OFF counter reaches 0 → PWRUP.
  - A timeout with retry_cnt = MAX_RETRY → FAIL.
  - retry_cnt clears in IDLE and LOCKED.
  - Lock loss in LOCKED also takes the retry path.
- SYNT_CTRL_RETRY_EN undefined:
  - No OFF state and no retry counter; every timeout or lock loss → FAIL.
  - MAX_RETRY is unused.
- T_OFF_CYC applies in both builds:
  - STOP→IDLE→START re-entry: IDLE enforces the off time by loading the counter on entry. START is not accepted until the count expires.

## Structure
- Shared package synt_pkg holds:
  - the state enum (IDLE, PWRUP, CAL, LOCKED, OFF, FAIL);
  - the CYC_PER_US=5 constant;
  - the Tcal+Trdy constant of 60 cycles;
  - the default timing values.
- A single sub-module, synt_dly_cnt: loadable down-counter of CNT_W bits with a zero flag. One instance is shared by all states.

## Test plan
- Nominal (defaults, synthesizer model needing 60 CAL cycles): RST then START → PU_SYNT at cycle 1, CAL_SYNT at cycle 11, SYNT_LOCK=1 within cycles 72–74, CAL_SYNT=0 on the same edge, SYNT_ERR=0.
- No RDY_SYNT (retry undefined): START → CAL_SYNT high for exactly 75 cycles, then PU_SYNT=0 and SYNT_ERR=1. START is ignored; STOP → SYNT_ERR=0 and IDLE.
- Retry (macro defined, RDY_SYNT tied low): three CAL windows of 75 cycles, each separated by ≥5 cycles of PU_SYNT=0, then SYNT_ERR=1. Variant: RDY_SYNT high in the second window → SYNT_LOCK=1, SYNT_ERR=0.
- STOP mid-CAL at cycle 30 → next edge all outputs 0, state IDLE. A new START is accepted no earlier than 5 cycles later.
- Lock loss: in LOCKED, drop RDY_SYNT for 1 cycle → SYNT_LOCK=0 and SYNT_ERR=1 on the next edge (retry undefined).
- RST asserted mid-PWRUP and RDY_SYNT/timeout coincident on the same edge → all outputs 0 after RST; RDY/timeout coincidence enters LOCKED.
